// File: rtl/cross_road_detector.sv
// Cross-road vehicle detector: synchronizes/debounces the loop sensor, queues cars and drives x.
// Optional starvation monitor enabled by defining CROSS_ROAD_DETECTOR_STARVE_EN.
module cross_road_detector #(
  parameter int unsigned DEBOUNCE   = 3,
  parameter int unsigned DEPART_CYC = 4,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned MAX_WAIT   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic [1:0]       highway,
  input  logic [1:0]       cross_road,
  output logic             x,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic             err_conflict,
  output logic             starve
);

  localparam int unsigned DEB_W = 4;
  localparam int unsigned TMR_W = 8;
  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, SERVE} state_t;

  // Elaboration-time parameter range checks
  if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
    $error("DEBOUNCE out of range");
  end
  if (DEPART_CYC < 1 || DEPART_CYC > 255) begin : g_bad_depart
    $error("DEPART_CYC out of range");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("MAX_WAIT out of range");
  end

  logic             sync_1, sync_q;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;
  logic [TMR_W-1:0] depart_tmr;
  state_t           state, state_next;

  logic             arrival, departure, depart_term, cr_green, conflict;
  logic             overflow_set;
  logic [CNT_W-1:0] count_next;

  // Two-flop synchronizer and debounce of the loop-sensor level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1    <= 1'b0;
      sync_q    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_1 <= sensor_raw;
      sync_q <= sync_1;
      if (sync_q == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE)) begin
        deb_level <= sync_q;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Arrival/departure decode, next count and next observational state
  always_comb begin
    arrival      = 1'b0;
    overflow_set = 1'b0;
    count_next   = car_count;
    state_next   = IDLE;
    cr_green     = (cross_road == LIGHT_GREEN);
    depart_term  = cr_green && (depart_tmr == TMR_W'(DEPART_CYC - 1));
    departure    = depart_term && (car_count != '0);
    conflict     = ((highway != LIGHT_RED) && (cross_road != LIGHT_RED)) ||
                   (highway == LIGHT_ILLEGAL) || (cross_road == LIGHT_ILLEGAL);

    if (sync_q && !deb_level && (deb_cnt == DEB_W'(DEBOUNCE)))
      arrival = 1'b1;

    if (arrival && !departure) begin
      if (car_count == CNT_MAX) overflow_set = 1'b1;
      else                      count_next   = car_count + CNT_W'(1);
    end else if (departure && !arrival) begin
      count_next = car_count - CNT_W'(1);
    end

    if (count_next == '0) state_next = IDLE;
    else if (cr_green)    state_next = SERVE;
    else                  state_next = WAIT;
  end

  // Queue counter, departure timer, state and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      car_count    <= '0;
      x            <= 1'b0;
      depart_tmr   <= '0;
      overflow     <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      state        <= state_next;
      car_count    <= count_next;
      x            <= (count_next != '0);
      overflow     <= overflow | overflow_set;
      err_conflict <= err_conflict | conflict;
      // Timer is already zero when SERVE follows WAIT; only a green IDLE period can leave it running
      if (!cr_green || depart_term || (state == IDLE && state_next == SERVE))
        depart_tmr <= '0;
      else
        depart_tmr <= depart_tmr + TMR_W'(1);
    end
  end

`ifdef CROSS_ROAD_DETECTOR_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_tmr;

  // Starvation monitor: consecutive WAIT edges, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_tmr <= '0;
      starve   <= 1'b0;
    end else if (state_next == WAIT) begin
      if (wait_tmr != WAIT_W'(MAX_WAIT)) wait_tmr <= wait_tmr + WAIT_W'(1);
      starve <= (wait_tmr >= WAIT_W'(MAX_WAIT - 1));
    end else begin
      wait_tmr <= '0;
      starve   <= 1'b0;
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_cross_road_detector.sv
// Directed self-checking bench for cross_road_detector (default parameters).
module tb_cross_road_detector;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] BAD    = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_raw = 1'b0;
  logic [1:0] highway = RED;
  logic [1:0] cross_road = RED;
  logic       x;
  logic [2:0] car_count;
  logic       overflow;
  logic       err_conflict;
  logic       starve;

  int n_cmp = 0;
  int n_err = 0;

  cross_road_detector dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_raw   (sensor_raw),
    .highway      (highway),
    .cross_road   (cross_road),
    .x            (x),
    .car_count    (car_count),
    .overflow     (overflow),
    .err_conflict (err_conflict),
    .starve       (starve)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sensor_raw = 1'b0;
    highway    = RED;
    cross_road = RED;
    rst        = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  task automatic vehicle();
    sensor_raw = 1'b1;
    tick(5);
    sensor_raw = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    sensor_raw = 1'b1;
    highway    = GREEN;
    cross_road = RED;
    rst        = 1'b0;
    tick(2);
    n_cmp++;
    if ({x, car_count, overflow, err_conflict, starve} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got x=%b cnt=%0d ovf=%b err=%b stv=%b, want all 0",
               x, car_count, overflow, err_conflict, starve);
    end
    rst = 1'b1;
    tick(5);
    n_cmp++;
    if (x !== 1'b0 || car_count !== 3'd0) begin
      n_err++;
      $display("FAIL latency_early: got x=%b cnt=%0d, want x=0 cnt=0", x, car_count);
    end
    tick(1);
    n_cmp++;
    if (x !== 1'b1 || car_count !== 3'd1) begin
      n_err++;
      $display("FAIL latency_exact: got x=%b cnt=%0d, want x=1 cnt=1", x, car_count);
    end
    sensor_raw = 1'b0;
    highway    = RED;
    tick(8);
  endtask

  task automatic test_glitch();
    do_reset();
    sensor_raw = 1'b1;
    tick(2);
    sensor_raw = 1'b0;
    tick(10);
    n_cmp++;
    if (x !== 1'b0 || car_count !== 3'd0) begin
      n_err++;
      $display("FAIL glitch: got x=%b cnt=%0d, want x=0 cnt=0", x, car_count);
    end
  endtask

  task automatic test_departure();
    int exp_cnt;
    do_reset();
    repeat (3) vehicle();
    n_cmp++;
    if (x !== 1'b1 || car_count !== 3'd3) begin
      n_err++;
      $display("FAIL queue3: got x=%b cnt=%0d, want x=1 cnt=3", x, car_count);
    end
    cross_road = GREEN;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp_cnt = (i >= 12) ? 0 : 3 - i / 4;
      n_cmp++;
      if (car_count !== 3'(exp_cnt) || x !== (exp_cnt != 0)) begin
        n_err++;
        $display("FAIL depart_c%0d: got x=%b cnt=%0d, want x=%b cnt=%0d",
                 i, x, car_count, (exp_cnt != 0), exp_cnt);
      end
    end
    cross_road = RED;
    tick(1);
  endtask

  task automatic test_overflow();
    do_reset();
    repeat (8) vehicle();
    n_cmp++;
    if (car_count !== 3'd7 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL saturate: got cnt=%0d ovf=%b, want cnt=7 ovf=1", car_count, overflow);
    end
    // Arrival lands on edge N+5; green from edge N+2 puts the terminal cycle on N+5 too
    sensor_raw = 1'b1;
    tick(2);
    cross_road = GREEN;
    tick(3);
    n_cmp++;
    if (car_count !== 3'd7) begin
      n_err++;
      $display("FAIL coincide_pre: got cnt=%0d, want 7", car_count);
    end
    tick(1);
    cross_road = RED;
    n_cmp++;
    if (car_count !== 3'd7) begin
      n_err++;
      $display("FAIL coincide: got cnt=%0d, want 7", car_count);
    end
    sensor_raw = 1'b0;
    tick(8);
    cross_road = GREEN;
    tick(4);
    cross_road = RED;
    n_cmp++;
    if (car_count !== 3'd6 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL depart_after_sat: got cnt=%0d ovf=%b, want cnt=6 ovf=1", car_count, overflow);
    end
    tick(1);
  endtask

  task automatic test_conflict();
    do_reset();
    highway    = GREEN;
    cross_road = RED;
    tick(2);
    n_cmp++;
    if (err_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_legal: got %b, want 0", err_conflict);
    end
    cross_road = YELLOW;
    tick(1);
    n_cmp++;
    if (err_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_set: got %b, want 1", err_conflict);
    end
    highway    = RED;
    cross_road = RED;
    tick(3);
    n_cmp++;
    if (err_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_sticky: got %b, want 1", err_conflict);
    end
    do_reset();
    tick(1);
    n_cmp++;
    if (err_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_clear: got %b, want 0", err_conflict);
    end
    highway = BAD;
    tick(1);
    highway = RED;
    n_cmp++;
    if (err_conflict !== 1'b1) begin
      n_err++;
      $display("FAIL conflict_code11: got %b, want 1", err_conflict);
    end
  endtask

  task automatic test_starve();
    do_reset();
    sensor_raw = 1'b1;
    tick(5);
    sensor_raw = 1'b0;
    tick(19);
    n_cmp++;
    if (starve !== 1'b0 || car_count !== 3'd1) begin
      n_err++;
      $display("FAIL starve_early: got stv=%b cnt=%0d, want stv=0 cnt=1", starve, car_count);
    end
    tick(1);
`ifdef CROSS_ROAD_DETECTOR_STARVE_EN
    n_cmp++;
    if (starve !== 1'b1) begin
      n_err++;
      $display("FAIL starve_set: got %b, want 1", starve);
    end
    cross_road = GREEN;
    tick(1);
    n_cmp++;
    if (starve !== 1'b0) begin
      n_err++;
      $display("FAIL starve_clear: got %b, want 0", starve);
    end
`else
    tick(5);
    n_cmp++;
    if (starve !== 1'b0) begin
      n_err++;
      $display("FAIL starve_disabled: got %b, want 0", starve);
    end
`endif
    cross_road = RED;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_departure();
    test_overflow();
    test_conflict();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
